// File: rtl/lsu_narrow_extend.sv
// -----------------------------------------------------------------------------
// lsu_narrow_extend
//
// Multi-cycle load/store unit sitting between the MIPS MEM stage and a
// req/ack data-memory bus (little-endian, 32-bit word addressed).
//   - Stores are narrowed to byte lanes: the store data is replicated across
//     the word and the byte enables select the lanes that are written.
//   - Loads pick the addressed byte/halfword out of the returned word and
//     sign- or zero-extend it to 32 bits.
//   - Misaligned halfword/word accesses never reach the bus; they raise a
//     one-cycle AdEL (load) or AdES (store) pulse with the faulting address.
//   - The pipeline is held with stall_o while the bus transaction is open.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   memread_i         load request from MEM stage
//   memwrite_i        store request from MEM stage (wins over memread_i)
//   size_i            00 byte, 01 half, 1x word
//   unsigned_i        zero-extend byte/half loads
//   addr_i, wdata_i   byte address, right-aligned store data
//   stall_o           freeze the pipeline (combinational on the request)
//   rdata_o           extended load result, held until the next load
//   rdata_valid_o     one-cycle pulse with a load result
//   adel_o, ades_o    one-cycle misaligned load / store pulse
//   badvaddr_o        faulting address, valid with adel_o / ades_o
//   mem_req_o .. mem_wdata_o   bus request, word address, lanes, data
//   mem_ack_i, mem_rdata_i     bus completion and read word (same cycle)
// -----------------------------------------------------------------------------
module lsu_narrow_extend (
   input  logic        clk,
   input  logic        rst,
   input  logic        memread_i,
   input  logic        memwrite_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        adel_o,
   output logic        ades_o,
   output logic [31:0] badvaddr_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   state_t      state_reg,    state_next;
   logic        we_reg,       we_next;
   logic [1:0]  size_reg,     size_next;
   logic        uns_reg,      uns_next;
   logic [31:0] addr_reg,     addr_next;
   logic [3:0]  be_reg,       be_next;
   logic [31:0] wdata_reg,    wdata_next;
   logic [31:0] rdata_reg,    rdata_next;
   logic [31:0] badvaddr_reg, badvaddr_next;

   logic        request;
   logic        misaligned;
   logic        in_req;

   // Store lane formatting, computed straight from the MEM-stage inputs so it
   // can be captured in the same cycle the request is accepted.
   logic [3:0]  st_be;
   logic [31:0] st_wdata;

   // Load lane extraction from the returned word, steered by the captured
   // address and size.
   logic [7:0]  rbyte [4];
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   assign request = memread_i | memwrite_i;

   // Size 2'b11 is treated as a word, so size_i[1] alone selects word rules.
   assign misaligned = (size_i == 2'b01 && addr_i[0]) ||
                       (size_i[1]       && addr_i[1:0] != 2'b00);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         // Byte: only lane k. Half: the lane pair selected by addr[1].
         assign st_be[gi] = size_i[1] ? 1'b1 :
                            size_i[0] ? (addr_i[1] == (gi >= 2)) :
                                        (addr_i[1:0] == 2'(gi));

         // Replicating the narrow datum across all lanes lets memory pick
         // whichever lanes are enabled without any shifting.
         assign st_wdata[8*gi +: 8] = size_i[1] ? wdata_i[8*gi +: 8] :
                                      size_i[0] ? wdata_i[8*(gi%2) +: 8] :
                                                  wdata_i[7:0];

         assign rbyte[gi] = mem_rdata_i[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      ld_byte = rbyte[addr_reg[1:0]];
      ld_half = addr_reg[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (size_reg)
         2'b00:   ld_ext = {{24{~uns_reg & ld_byte[7]}},  ld_byte};
         2'b01:   ld_ext = {{16{~uns_reg & ld_half[15]}}, ld_half};
         default: ld_ext = mem_rdata_i;
      endcase
   end

   // Next-state and capture logic.
   always_comb begin
      state_next    = state_reg;
      we_next       = we_reg;
      size_next     = size_reg;
      uns_next      = uns_reg;
      addr_next     = addr_reg;
      be_next       = be_reg;
      wdata_next    = wdata_reg;
      rdata_next    = rdata_reg;
      badvaddr_next = badvaddr_reg;

      case (state_reg)
         ST_IDLE: begin
            if (request) begin
               we_next   = memwrite_i;
               size_next = size_i;
               uns_next  = unsigned_i;
               addr_next = addr_i;
               if (misaligned) begin
                  badvaddr_next = addr_i;
                  state_next    = ST_FAULT;
               end else begin
                  // Loads drive no byte enables and no write data.
                  be_next    = memwrite_i ? st_be    : 4'b0000;
                  wdata_next = memwrite_i ? st_wdata : 32'h0;
                  state_next = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_ack_i) begin
               if (!we_reg) begin
                  rdata_next = ld_ext;
               end
               state_next = ST_DONE;
            end
         end
         ST_DONE:  state_next = ST_IDLE;
         ST_FAULT: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         we_reg       <= 1'b0;
         size_reg     <= 2'b00;
         uns_reg      <= 1'b0;
         addr_reg     <= 32'h0;
         be_reg       <= 4'b0000;
         wdata_reg    <= 32'h0;
         rdata_reg    <= 32'h0;
         badvaddr_reg <= 32'h0;
      end else begin
         state_reg    <= state_next;
         we_reg       <= we_next;
         size_reg     <= size_next;
         uns_reg      <= uns_next;
         addr_reg     <= addr_next;
         be_reg       <= be_next;
         wdata_reg    <= wdata_next;
         rdata_reg    <= rdata_next;
         badvaddr_reg <= badvaddr_next;
      end
   end

   // Bus outputs are gated by state so they are quiet outside REQ and drop
   // immediately when reset abandons an open transaction.
   assign in_req      = (state_reg == ST_REQ);
   assign mem_req_o   = in_req;
   assign mem_we_o    = in_req & we_reg;
   assign mem_addr_o  = in_req ? {addr_reg[31:2], 2'b00} : 32'h0;
   assign mem_be_o    = in_req ? be_reg    : 4'b0000;
   assign mem_wdata_o = in_req ? wdata_reg : 32'h0;

   // The only input-combinational output: the pipeline must freeze in the
   // same cycle it presents the request.
   assign stall_o = ((state_reg == ST_IDLE) & request) | in_req;

   assign rdata_o       = rdata_reg;
   assign rdata_valid_o = (state_reg == ST_DONE)  & ~we_reg;
   assign adel_o        = (state_reg == ST_FAULT) & ~we_reg;
   assign ades_o        = (state_reg == ST_FAULT) &  we_reg;
   assign badvaddr_o    = badvaddr_reg;

endmodule

// File: tb/tb_lsu_narrow_extend.sv
module tb_lsu_narrow_extend;

   logic        clk = 1'b0;
   logic        rst;
   logic        memread_i, memwrite_i, unsigned_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, rdata_valid_o, adel_o, ades_o;
   logic [31:0] rdata_o, badvaddr_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   lsu_narrow_extend dut (
      .clk(clk), .rst(rst),
      .memread_i(memread_i), .memwrite_i(memwrite_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
      .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      logic        fault;
      logic        we;
      logic [31:0] val;
   } resp_t;

   bus_t  bus_q[$];
   resp_t resp_q[$];

   int          checks = 0;
   int          errors = 0;
   int          txn    = 0;
   int          wait_n = 0;
   logic [31:0] mem_word = 32'h0;
   logic        force_ack = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Issue one MEM-stage access, push its expected bus/response behaviour,
   // and hold it until the unit releases the stall.
   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] word, input int n);
      int          k, stall_cnt, req_cnt, exp_stall, exp_req;
      logic        mis, done;
      longint      v;
      int unsigned lane;
      bus_t        b;
      resp_t       r;
      @(posedge clk); #1;
      k         = int'(a % 4);
      mis       = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && k != 0);
      wait_n    = n;
      mem_word  = word;
      memread_i = rd; memwrite_i = wr; size_i = sz; unsigned_i = uns;
      addr_i    = a;  wdata_i    = d;
      txn++;
      $display("txn %0d: %s size=%0d uns=%0d addr=%08h wdata=%08h word=%08h wait=%0d misaligned=%0d",
               txn, wr ? "store" : "load", sz, uns, a, d, word, n, mis);
      if (mis) begin
         r.fault = 1'b1; r.we = wr; r.val = a;
         resp_q.push_back(r);
         exp_stall = 1; exp_req = 0;
      end else begin
         b.we   = wr;
         b.addr = a - 32'(k);
         if (wr) begin
            case (sz)
               2'd0:    begin b.be = 4'(1 << k); b.wdata = (d % 256)   * 32'h0101_0101; end
               2'd1:    begin b.be = 4'(3 << k); b.wdata = (d % 65536) * 32'h0001_0001; end
               default: begin b.be = 4'hF;       b.wdata = d; end
            endcase
         end else begin
            b.be = 4'h0; b.wdata = 32'h0;
         end
         bus_q.push_back(b);
         if (!wr) begin
            lane = word >> (8 * k);
            if (sz == 2'd0) begin
               v = lane % 256;
               if (!uns && v >= 128) v = v - 256;
            end else if (sz == 2'd1) begin
               v = lane % 65536;
               if (!uns && v >= 32768) v = v - 65536;
            end else begin
               v = word;
            end
            r.fault = 1'b0; r.we = 1'b0; r.val = 32'(v);
            resp_q.push_back(r);
         end
         exp_stall = n + 2; exp_req = n + 1;
      end
      stall_cnt = 0; req_cnt = 0; done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk); #1;
         if (mem_req_o) req_cnt++;
         if (stall_o) stall_cnt++;
         else done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL stall_timeout actual=stuck required=release txn=%0d", txn);
      end
      chk("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
      chk("req_cycles",   64'(req_cnt),   64'(exp_req));
   endtask

   // Memory responder: acks in REQ cycle wait_n+1 with the chosen word.
   initial begin
      int cnt = 0;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_req_o) begin
            if (cnt == wait_n) begin mem_ack_i = 1'b1; mem_rdata_i = mem_word; end
            else               begin mem_ack_i = 1'b0; mem_rdata_i = $urandom; end
            cnt++;
         end else begin
            cnt = 0;
            mem_ack_i   = force_ack;
            mem_rdata_i = $urandom;
         end
      end
   end

   // Monitor: compares every bus completion and every result pulse against
   // the scoreboard queues.
   initial begin
      logic        prev_req = 1'b0, prev_we = 1'b0;
      logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
      logic [3:0]  prev_be = 4'h0;
      bus_t        b;
      resp_t       r;
      forever begin
         @(negedge clk); #2;
         if (mem_req_o && prev_req) begin
            chk("bus_addr_stable", mem_addr_o, prev_addr);
            chk("bus_ctl_stable", {mem_we_o, mem_be_o, mem_wdata_o},
                {prev_we, prev_be, prev_wdata});
         end
         prev_req = mem_req_o; prev_we = mem_we_o; prev_addr = mem_addr_o;
         prev_be = mem_be_o; prev_wdata = mem_wdata_o;

         if (mem_req_o && mem_ack_i) begin
            if (bus_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL bus_unexpected actual=addr %08h required=no access", mem_addr_o);
            end else begin
               b = bus_q.pop_front();
               chk("bus_addr", mem_addr_o, b.addr);
               chk("bus_we",   mem_we_o,   b.we);
               chk("bus_be",   mem_be_o,   b.be);
               if (b.we) chk("bus_wdata", mem_wdata_o, b.wdata);
            end
         end

         if (rdata_valid_o || adel_o || ades_o) begin
            if (resp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL resp_unexpected actual=valid%0d adel%0d ades%0d required=none",
                        rdata_valid_o, adel_o, ades_o);
            end else begin
               r = resp_q.pop_front();
               chk("resp_kind", {rdata_valid_o, adel_o, ades_o},
                   r.fault ? (r.we ? 3'b001 : 3'b010) : 3'b100);
               if (r.fault) chk("badvaddr", badvaddr_o, r.val);
               else         chk("rdata",    rdata_o,    r.val);
            end
         end
      end
   end

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          op;
      rst = 1'b1;
      memread_i = 1'b0; memwrite_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
      addr_i = 32'h0; wdata_i = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      chk("reset_ctl", {stall_o, rdata_valid_o, adel_o, ades_o, mem_req_o, mem_we_o, mem_be_o}, 0);
      chk("reset_data", {rdata_o, badvaddr_o}, 0);

      // Directed cases
      issue(1, 0, 2'd0, 0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);          // lb
      issue(1, 0, 2'd0, 1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);          // lbu
      issue(0, 1, 2'd1, 0, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 0);          // sh
      issue(1, 0, 2'd2, 0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 3);          // lw, 3 waits
      issue(1, 0, 2'd1, 0, 32'h0000_4001, 32'h0, 32'h0, 0);                  // lh misaligned
      issue(0, 1, 2'd2, 0, 32'h0000_4002, 32'h1234_5678, 32'h0, 0);          // sw misaligned
      issue(1, 1, 2'd0, 0, 32'h0000_5001, 32'h0000_00A5, 32'h0, 1);          // both set -> sb
      issue(1, 0, 2'd1, 0, 32'h0000_6002, 32'h0, 32'h9ABC_0001, 2);          // lh upper half

      // Randomized traffic, back to back
      for (int i = 0; i < 40; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            else if (sz[1]) a[1:0] = 2'b00;
         end
         op = $urandom_range(0, 3);
         issue(op != 2, op >= 2, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
               $urandom_range(0, 4));
      end

      // Reset in the second REQ cycle of a load, then a stale ack.
      @(posedge clk); #1;
      wait_n = 1000;
      memread_i = 1'b1; memwrite_i = 1'b0; size_i = 2'd2; addr_i = 32'h0000_7000;
      $display("txn %0d: load with reset in second REQ cycle addr=%08h", txn + 1, addr_i);
      @(posedge clk); #1;
      chk("rst_req_open", mem_req_o, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; memread_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_ctl", {stall_o, rdata_valid_o, adel_o, ades_o, mem_req_o, mem_we_o, mem_be_o}, 0);
      chk("rst_mid_data", {rdata_o, badvaddr_o}, 0);
      chk("rst_mid_bus", {mem_addr_o, mem_wdata_o}, 0);
      force_ack = 1'b1;
      @(posedge clk); #1;
      force_ack = 1'b0;
      chk("late_ack_valid", {rdata_valid_o, mem_req_o, stall_o}, 0);
      @(posedge clk); #1;
      chk("late_ack_quiet", {rdata_valid_o, mem_req_o, rdata_o}, 0);

      // Recovery after reset
      issue(1, 0, 2'd0, 0, 32'h0000_8002, 32'h0, 32'h0055_7F00, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("bus_q_drained",  64'(bus_q.size()),  0);
      chk("resp_q_drained", 64'(resp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_narrow_extend.md
# lsu_narrow_extend

Multi-cycle load/store unit between the MIPS MEM stage and the data-memory bus. Stores are narrowed to byte lanes with byte enables; loaded bytes and halfwords are extracted and sign- or zero-extended to 32 bits. The pipeline is stalled over a req/ack memory handshake with variable latency. Misaligned accesses are flagged as AdEL or AdES instead of reaching memory.

## Interface
- No parameters. Data and address are fixed at 32 bits. Memory is little-endian.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- memread_i  in  1  MEM-stage load request
- memwrite_i  in  1  MEM-stage store request; wins if both requests are set
- size_i  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = treated as word
- unsigned_i  in  1  zero-extend the load (lbu/lhu); ignored for word loads and all stores
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- stall_o  out  1  freeze the pipeline
- rdata_o  out  32  extended load result; valid when rdata_valid_o = 1
- rdata_valid_o  out  1  one-cycle pulse with the load result
- adel_o / ades_o  out  1  one-cycle pulse: misaligned load / misaligned store
- badvaddr_o  out  32  faulting address; valid with adel_o or ades_o
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word address, {addr_i[31:2], 2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated write data
- mem_ack_i  in  1  bus completion; read data is valid in the same cycle
- mem_rdata_i  in  32  read word

## Operation
- States: IDLE, REQ, DONE, FAULT.
- IDLE:
  - A request is memread_i | memwrite_i.
  - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
  - Aligned request: capture we, size, unsigned, addr, be, wdata; next state is REQ.
  - Misaligned request: capture addr into badvaddr_o; next state is FAULT.
  - stall_o = 1 combinationally while IDLE sees any request.
- REQ:
  - mem_req_o = 1, stall_o = 1.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o come from captured registers and stay stable until ack.
  - On mem_ack_i: for a load, register the extended result; next state is DONE.
- DONE: stall_o = 0; rdata_valid_o = 1 for a load, 0 for a store. Inputs are ignored. Next state is IDLE.
- FAULT: stall_o = 0; adel_o (load) or ades_o (store) = 1. No bus access occurs. Next state is IDLE.
- Store formatting, with k = addr[1:0]:
  - Byte: be = 4'b0001 << k; wdata = {4{wdata_i[7:0]}}.
  - Half: be = 4'b0011 (k = 0) or 4'b1100 (k = 2); wdata = {2{wdata_i[15:0]}}.
  - Word: be = 4'b1111; wdata = wdata_i.
- Load formatting:
  - Byte lane is mem_rdata_i[8k+7:8k]; half lane is mem_rdata_i[8k+15:8k].
  - Bit 7 (byte) or bit 15 (half) is replicated upward; zeros are used instead when unsigned_i = 1.
  - Word loads pass through unchanged.
- rdata_o holds its value until the next load completes.
- Reset (any state, including mid-REQ):
  - Next state is IDLE.
  - All outputs are 0 from the following cycle; mem_req_o deasserts without waiting for ack.
  - A stale mem_ack_i seen in IDLE is ignored.
- mem_ack_i outside REQ is ignored.

## Timing
- Aligned access with N wait cycles, where ack arrives in REQ cycle N+1:
  - Cycle 0 is IDLE with stall_o = 1.
  - Cycles 1..N+1 are REQ.
  - Cycle N+2 is DONE, with stall_o = 0 and rdata_valid_o = 1 for a load.
  - Stall length is N+2 cycles.
- Zero-wait access: 3 cycles total, stall_o high for 2 cycles.
- Misaligned access: stall_o high in cycle 0; adel_o or ades_o high in cycle 1 with stall_o = 0. Total 2 cycles, with no mem_req_o.
- A new request is accepted in the cycle after DONE or FAULT; back-to-back accesses have no extra bubble.
- rdata_o, rdata_valid_o, adel_o, ades_o, badvaddr_o and mem_* are registered or decoded from state. stall_o is the only output combinational on inputs.

## Test plan
- lb addr 0x1003, mem word 0x80FF_1234, ack at zero wait:
  - mem_addr_o = 0x1000, mem_be_o = 4'b0000, mem_we_o = 0.
  - rdata_o = 0xFFFF_FF80 in cycle 2; lbu gives 0x0000_0080.
- sh addr 0x2002, wdata 0xDEAD_BEEF:
  - mem_be_o = 4'b1100, mem_wdata_o = 0xBEEF_BEEF.
  - DONE with rdata_valid_o = 0; stall_o high for exactly 2 cycles.
- lw addr 0x3000, ack after 3 wait cycles:
  - mem_req_o high for 4 cycles with stable address.
  - rdata_o = mem word; stall_o high for 5 cycles.
- lh addr 0x4001 -> adel_o = 1 and badvaddr_o = 0x4001 in cycle 1; no mem_req_o.
- sw addr 0x4002 -> ades_o = 1, badvaddr_o = 0x4002.
- rst asserted in the second REQ cycle -> mem_req_o = 0 next cycle and all outputs 0. A late ack produces no rdata_valid_o.
